// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side control blocks: default FIFO
// geometry, occupancy counter width and the round-robin pick function.
package fifo_ctrl_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int LVL_W          = $clog2(DEF_FIFO_DEPTH + 1);

  // The pick function works on the largest supported requester count; callers
  // zero-extend their request vector and pass the live width in n.
  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  // One-hot grant of the first set request at or after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [PTR_W-1:0]   ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] g;
    logic               found;
    int                 idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        idx = int'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[PTR_W-1:0]]) begin
          g[idx[PTR_W-1:0]] = 1'b1;
          found             = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer and FIFO write-side signals seen by the write arbiter.
// master: the arbiter; slave: producers plus the attached FIFO.
interface fifo_wr_arbiter_if
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_rd_fire;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
  logic [LEVEL_W-1:0]            level;
  logic                          ovf_err;
  logic                          ack_err;

  modport master (
    input  req, req_data, fifo_rd_fire, fifo_wr_ack, fifo_overflow,
    output gnt, fifo_wr_en, fifo_data_in, level, ovf_err, ack_err
  );

  modport slave (
    output req, req_data, fifo_rd_fire, fifo_wr_ack, fifo_overflow,
    input  gnt, fifo_wr_en, fifo_data_in, level, ovf_err, ack_err
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at rr_ptr, pointer moves
// past the winner on every grant. Grants are suppressed while en is low or
// while reset is asserted.
module rr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      ptr_nxt;
  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick;

  // Pick the first requester at or after rr_ptr; gate with enable and reset.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_pick(req_ext, PTR_W'(rr_ptr), N);
    gnt            = (rst || !en) ? '0 : pick[N-1:0];
  end

  // Next pointer is one past the winner, wrapping to 0 after N-1.
  always_comb begin
    ptr_nxt = rr_ptr;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) ptr_nxt = (i == N - 1) ? '0 : PW'(i + 1);
    end
  end

  // Pointer advances only on a grant.
  always_ff @(posedge clk) begin
    if (rst)       rr_ptr <= '0;
    else if (|gnt) rr_ptr <= ptr_nxt;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NUM_REQ producers. Tracks committed
// occupancy so a write is never issued into a full FIFO, registers the write
// side, and raises sticky flags on bad wr_ack / overflow responses.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

  logic                  can_issue_p0;
  logic [NUM_REQ-1:0]    gnt_p0;
  logic                  vld_p0;
  logic [FIFO_WIDTH-1:0] data_p0;
  logic                  rd_dec;
  logic                  rd_under;
  logic                  ack_pending;

  // A read in the same cycle is deliberately not credited here.
  assign can_issue_p0 = (bus.level < LEVEL_W'(FIFO_DEPTH));

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk (clk),
    .rst (rst),
    .en  (can_issue_p0),
    .req (bus.req),
    .gnt (gnt_p0)
  );

  assign bus.gnt = gnt_p0;
  assign vld_p0  = |gnt_p0;

  // Select the granted producer's data slice.
  always_comb begin
    data_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_p0[i]) data_p0 = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // A read at level 0 cannot be real; it is dropped from the count and flagged.
  assign rd_dec   = bus.fifo_rd_fire && (bus.level != '0);
  assign rd_under = bus.fifo_rd_fire && (bus.level == '0);

  // ---- p0 -> p1: registered FIFO write and committed occupancy ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fifo_wr_en   <= 1'b0;
      bus.fifo_data_in <= '0;
      bus.level        <= '0;
    end else begin
      bus.fifo_wr_en <= vld_p0;
      if (vld_p0) bus.fifo_data_in <= data_p0;
      bus.level <= bus.level + LEVEL_W'(vld_p0) - LEVEL_W'(rd_dec);
    end
  end

  // Response checkers: wr_ack must follow wr_en by exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_pending <= 1'b0;
      bus.ack_err <= 1'b0;
      bus.ovf_err <= 1'b0;
    end else begin
      ack_pending <= bus.fifo_wr_en;
      if ((ack_pending != bus.fifo_wr_ack) || rd_under) bus.ack_err <= 1'b1;
      if (bus.fifo_overflow) bus.ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: grants, level and flags checked in the
// stimulus thread; every expected FIFO write is queued and a monitor compares
// it against fifo_data_in whenever fifo_wr_en is high.
module tb_fifo_wr_arbiter;
  import fifo_ctrl_pkg::*;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drop_ack = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] d1[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // FIFO write-side model: wr_ack one cycle after wr_en, unless dropped.
  always @(posedge clk) begin
    if (rst) bus.fifo_wr_ack <= 1'b0;
    else     bus.fifo_wr_ack <= bus.fifo_wr_en & ~drop_ack;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h required 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Check grant and queue the write it should produce next cycle.
  task automatic expg(input string nm, input int g, input logic [W-1:0] d);
    chk(nm, int'(bus.gnt), g);
    if (g != 0) exp_q.push_back(d);
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for FIFO writes.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && bus.fifo_wr_en) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_data: unexpected write 'h%0h, none queued at %0t", bus.fifo_data_in, $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.fifo_data_in !== e) begin
          n_err++;
          $display("FAIL wr_data: got 'h%0h required 'h%0h at %0t", bus.fifo_data_in, e, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    bus.req           = '0;
    bus.req_data      = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    bus.fifo_rd_fire  = 1'b0;
    bus.fifo_overflow = 1'b0;
    rst               = 1'b1;
    to_pos();
    to_pos();

    // Reset state, with requests present: grant forced low.
    bus.req = 4'b1111;
    to_neg();
    chk("rst_gnt",   int'(bus.gnt), 0);
    chk("rst_wren",  int'(bus.fifo_wr_en), 0);
    chk("rst_data",  int'(bus.fifo_data_in), 0);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_ovf",   int'(bus.ovf_err), 0);
    chk("rst_ack",   int'(bus.ack_err), 0);
    to_pos();
    rst = 1'b0;

    // All requesting: rotation 0,1,2,3,0,1,2,3 until full.
    for (int i = 0; i < 8; i++) begin
      to_neg();
      chk("t1_level", int'(bus.level), i);
      chk("t1_wren", int'(bus.fifo_wr_en), (i > 0) ? 1 : 0);
      expg("t1_gnt", 1 << (i % 4), d1[i % 4]);
      to_pos();
    end
    to_neg();
    chk("t1_full_gnt", int'(bus.gnt), 0);
    chk("t1_full_lvl", int'(bus.level), 8);
    chk("t1_last_wr",  int'(bus.fifo_wr_en), 1);
    to_pos();
    to_neg();
    chk("t1_stall_gnt", int'(bus.gnt), 0);
    chk("t1_wren_off",  int'(bus.fifo_wr_en), 0);
    to_pos();

    // One read at full frees exactly one slot.
    bus.fifo_rd_fire = 1'b1;
    to_neg();
    chk("t2_gnt_rd", int'(bus.gnt), 0);
    chk("t2_lvl_rd", int'(bus.level), 8);
    to_pos();
    bus.fifo_rd_fire = 1'b0;
    to_neg();
    chk("t2_lvl7", int'(bus.level), 7);
    expg("t2_gnt", 4'b0001, 16'h1111);
    to_pos();
    to_neg();
    chk("t2_lvl8", int'(bus.level), 8);
    chk("t2_gnt0", int'(bus.gnt), 0);
    chk("t2_ackerr", int'(bus.ack_err), 0);
    to_pos();

    // Drain to 5, then grant plus read in one cycle.
    bus.req          = '0;
    bus.req_data     = {16'h0D0D, 16'hA5A5, 16'h0B0B, 16'h0A0A};
    bus.fifo_rd_fire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("t3_drain", int'(bus.level), 8 - i);
      to_pos();
    end
    bus.req = 4'b0100;
    to_neg();
    chk("t3_lvl5", int'(bus.level), 5);
    expg("t3_gnt2", 4'b0100, 16'hA5A5);
    to_pos();

    // rr_ptr is now 3: wrap to producer 0, then pointer sits at 1.
    bus.fifo_rd_fire = 1'b0;
    bus.req          = 4'b0001;
    to_neg();
    chk("t3_lvl_hold", int'(bus.level), 5);
    chk("t3_data",     int'(bus.fifo_data_in), 16'hA5A5);
    expg("t4_wrap", 4'b0001, 16'h0A0A);
    to_pos();
    bus.req = 4'b0011;
    to_neg();
    chk("t4_lvl6", int'(bus.level), 6);
    expg("t4_ptr1", 4'b0010, 16'h0B0B);
    to_pos();
    bus.req = '0;
    to_neg();
    chk("t4_lvl7", int'(bus.level), 7);
    chk("t4_idle", int'(bus.gnt), 0);
    to_pos();

    // One more write, its ack dropped, then an overflow pulse.
    bus.req = 4'b0001;
    to_neg();
    chk("t5_ack_pre", int'(bus.ack_err), 0);
    chk("t5_ovf_pre", int'(bus.ovf_err), 0);
    expg("t5_gnt", 4'b0001, 16'h0A0A);
    to_pos();
    bus.req  = '0;
    drop_ack = 1'b1;
    to_neg();
    chk("t5_lvl8", int'(bus.level), 8);
    chk("t5_wren", int'(bus.fifo_wr_en), 1);
    to_pos();
    drop_ack = 1'b0;
    to_neg();
    chk("t5_ack_miss", int'(bus.ack_err), 0);
    to_pos();
    bus.fifo_overflow = 1'b1;
    to_neg();
    chk("t5_ack_set", int'(bus.ack_err), 1);
    chk("t5_ovf_pre2", int'(bus.ovf_err), 0);
    to_pos();
    bus.fifo_overflow = 1'b0;
    to_neg();
    chk("t5_ovf_set", int'(bus.ovf_err), 1);
    chk("t5_ack_hold", int'(bus.ack_err), 1);
    to_pos();

    // Bring level to 6, then reset with requests active.
    bus.fifo_rd_fire = 1'b1;
    to_neg();
    chk("t6_ovf_hold", int'(bus.ovf_err), 1);
    chk("t6_lvl8", int'(bus.level), 8);
    to_pos();
    to_neg();
    chk("t6_lvl7", int'(bus.level), 7);
    to_pos();
    bus.fifo_rd_fire = 1'b0;
    rst              = 1'b1;
    bus.req          = 4'b1111;
    to_neg();
    chk("t6_rst_gnt", int'(bus.gnt), 0);
    chk("t6_lvl6", int'(bus.level), 6);
    to_pos();
    to_neg();
    chk("t6_rst_lvl", int'(bus.level), 0);
    chk("t6_rst_ovf", int'(bus.ovf_err), 0);
    chk("t6_rst_ack", int'(bus.ack_err), 0);
    chk("t6_rst_gnt2", int'(bus.gnt), 0);
    chk("t6_rst_wren", int'(bus.fifo_wr_en), 0);
    to_pos();
    rst     = 1'b0;
    bus.req = 4'b0110;
    to_neg();
    chk("t6_lvl0", int'(bus.level), 0);
    expg("t6_first", 4'b0010, 16'h0B0B);
    to_pos();
    bus.req = '0;
    to_neg();
    chk("t6_lvl1", int'(bus.level), 1);
    chk("t6_wren", int'(bus.fifo_wr_en), 1);
    to_pos();
    to_neg();
    chk("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's synchronous FIFO among NUM_REQ producers.
- Keeps its own occupancy count so it never issues a write into a full FIFO.
- Drives the FIFO write side with registered signals.
- Checks the FIFO's wr_ack and overflow responses and raises sticky error flags.

Parameters:
- NUM_REQ, 4: number of producers (2..8).
- FIFO_WIDTH, 16: data width; must match the attached FIFO.
- FIFO_DEPTH, 8: entries in the attached FIFO; sets the credit limit.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset; shared with the attached FIFO.
- req  in  NUM_REQ  per-producer write request; level, held until granted.
- req_data  in  NUM_REQ*FIFO_WIDTH  packed producer data; slice i belongs to producer i.
- gnt  out  NUM_REQ  one-hot; gnt[i]=1 means req_data slice i is consumed this cycle.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_data_in  out  FIFO_WIDTH  to FIFO data_in.
- fifo_rd_fire  in  1  successful FIFO read this cycle (rd_en & ~empty), supplied by the read side.
- fifo_wr_ack  in  1  from FIFO wr_ack.
- fifo_overflow  in  1  from FIFO overflow.
- level  out  $clog2(FIFO_DEPTH+1)  committed occupancy (granted writes minus reads).
- ovf_err  out  1  sticky: FIFO reported overflow.
- ack_err  out  1  sticky: wr_ack missing when expected, or present when not expected.

Behaviour:
- Reset (rst=1 at a clk edge):
  - gnt=0, fifo_wr_en=0, fifo_data_in=0, level=0, ovf_err=0, ack_err=0.
  - rr_ptr=0, ack_pending=0.
  - gnt is also forced 0 combinationally while rst=1.
- Reset mid-operation: all in-flight state is discarded. Producers see no grant and must keep req asserted. The FIFO is reset by the same rst, so level=0 stays consistent with it.
- Credit: can_issue = (level < FIFO_DEPTH). A read in the same cycle is not counted toward can_issue (conservative).
- Arbitration, combinational in cycle t:
  - If can_issue, search req starting at index rr_ptr, ascending with wrap to 0; the first set bit k wins and gnt[k]=1.
  - Otherwise gnt=0.
- Pointer: on any grant to k, rr_ptr <= (k+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Write issue, registered:
  - At the edge ending cycle t: fifo_wr_en <= |gnt, and fifo_data_in <= req_data[k] when granted (holds its value otherwise).
  - Latency from a granted req to the FIFO wr_en is 1 cycle.
- Level update each edge: level <= level + (|gnt) - fifo_rd_fire.
  - A grant and a read in the same cycle leave level unchanged.
  - A read at level=0 is ignored (saturate at 0) and sets ack_err.
  - level never exceeds FIFO_DEPTH.
- Ack check:
  - ack_pending <= fifo_wr_en.
  - In any cycle where ack_pending != fifo_wr_ack, ack_err <= 1.
  - The FIFO's wr_ack is a single-cycle pulse, registered one cycle after wr_en.
- Overflow check: fifo_overflow=1 in any cycle sets ovf_err <= 1. It must never fire in correct operation.
- Error flags stay set until rst.
- Full boundary:
  - At level=FIFO_DEPTH all requests stall.
  - A read in cycle t makes level=FIFO_DEPTH-1 at t+1, and a grant is possible in t+1.
- Wrap boundary: with rr_ptr=NUM_REQ-1 and only req[0] set, producer 0 is granted and rr_ptr becomes 1.
- Back-to-back: a producer holding req continuously is granted at most once every NUM_REQ cycles while all producers are requesting. A sole requester is granted every cycle while credit remains.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - FIFO_WIDTH/FIFO_DEPTH defaults.
  - LVL_W = $clog2(FIFO_DEPTH+1).
  - A function rr_pick(req, ptr) returning a one-hot grant.
- Sub-module rr_arbiter (parameter N) contains the combinational pick and the rr_ptr register, with an enable input (= can_issue).
- Top level holds the credit counter, output registers and checkers.

Test Plan:
- Reset then req=4'b1111 held, no reads: grants 0,1,2,3,0,1,2,3 over 8 cycles. level reaches 8 and gnt=0 afterwards. fifo_wr_en high for exactly 8 cycles, delayed 1 cycle from gnt.
- level=8, assert fifo_rd_fire for 1 cycle: level=7 next cycle. One grant goes to the next producer in rotation, then level returns to 8.
- level=5, grant and fifo_rd_fire in the same cycle: level stays 5. fifo_data_in equals the granted producer's slice, e.g. 16'hA5A5 from producer 2.
- rr_ptr=3, req=4'b0001: gnt=4'b0001, rr_ptr becomes 1. Then req=4'b0011: gnt=4'b0010.
- Model a FIFO that drops one wr_ack, then inject fifo_overflow=1: ack_err=1 one cycle after the missing ack, ovf_err=1 next cycle. Both hold until rst.
- Assert rst while level=6 with req active: gnt=0 during rst. After release level=0, rr_ptr=0, flags clear, and the first grant goes to the lowest-index requester.
